// File: rtl/native2axil_adapter_pkg.sv
// Shared AXI4-lite definitions for the native-to-AXI4-lite bridge.
// Holds the response width, the OKAY code and the response classifier.
package native2axil_adapter_pkg;

   localparam int AXI_RESP_W = 2;
   localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

   // Any response other than OKAY is reported to the initiator as an error.
   function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
      return (resp != AXI_RESP_OKAY);
   endfunction

endpackage

// File: rtl/native2axil_adapter.sv
// Native valid/ready slave to AXI4-lite master bridge: one native request becomes
// one AXI4-lite write (AW+W+B) or read (AR+R); at most one transaction in flight.
module native2axil_adapter
   import native2axil_adapter_pkg::*;
#(
   parameter int AXIL_ADDR_W = 32,
   parameter int AXIL_DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   input  logic [AXIL_ADDR_W-1:0]     addr,
   input  logic [AXIL_DATA_W-1:0]     wdata,
   input  logic [AXIL_DATA_W/8-1:0]   wstrb,
   output logic [AXIL_DATA_W-1:0]     rdata,
   output logic                       ready,
   output logic                       error,
   output logic [AXIL_ADDR_W-1:0]     m_axil_awaddr,
   output logic [2:0]                 m_axil_awprot,
   output logic                       m_axil_awvalid,
   input  logic                       m_axil_awready,
   output logic [AXIL_DATA_W-1:0]     m_axil_wdata,
   output logic [AXIL_DATA_W/8-1:0]   m_axil_wstrb,
   output logic                       m_axil_wvalid,
   input  logic                       m_axil_wready,
   input  logic [AXI_RESP_W-1:0]      m_axil_bresp,
   input  logic                       m_axil_bvalid,
   output logic                       m_axil_bready,
   output logic [AXIL_ADDR_W-1:0]     m_axil_araddr,
   output logic [2:0]                 m_axil_arprot,
   output logic                       m_axil_arvalid,
   input  logic                       m_axil_arready,
   input  logic [AXIL_DATA_W-1:0]     m_axil_rdata,
   input  logic [AXI_RESP_W-1:0]      m_axil_rresp,
   input  logic                       m_axil_rvalid,
   output logic                       m_axil_rready
);

   localparam int STRB_W = AXIL_DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_W_RESP = 3'd2,
      ST_READ   = 3'd3,
      ST_R_DATA = 3'd4
   } state_t;

   state_t                   state_r, state_s;
   logic                     awvalid_r, awvalid_s;
   logic                     wvalid_r, wvalid_s;
   logic                     arvalid_r, arvalid_s;
   logic                     bready_r, bready_s;
   logic                     rready_r, rready_s;
   logic                     ready_r, ready_s;
   logic                     error_r, error_s;
   logic [AXIL_DATA_W-1:0]   rdata_r, rdata_s;
   logic                     aw_done_r, aw_done_s;
   logic                     w_done_r, w_done_s;

   // Payloads pass straight through; the initiator holds them until ready.
   assign m_axil_awaddr  = addr;
   assign m_axil_araddr  = addr;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_wdata   = wdata;
   assign m_axil_wstrb   = wstrb;
   assign m_axil_awvalid = awvalid_r;
   assign m_axil_wvalid  = wvalid_r;
   assign m_axil_arvalid = arvalid_r;
   assign m_axil_bready  = bready_r;
   assign m_axil_rready  = rready_r;
   assign ready          = ready_r;
   assign error          = error_r;
   assign rdata          = rdata_r;

   // Next-state and next-output logic for the shared write/read FSM.
   always_comb begin
      state_s   = state_r;
      awvalid_s = awvalid_r;
      wvalid_s  = wvalid_r;
      arvalid_s = arvalid_r;
      bready_s  = bready_r;
      rready_s  = rready_r;
      aw_done_s = aw_done_r;
      w_done_s  = w_done_r;
      rdata_s   = rdata_r;
      ready_s   = 1'b0;
      error_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // ready_r masks the still-high valid of the request just completed.
            if (valid && !ready_r) begin
               if (wstrb != {STRB_W{1'b0}}) begin
                  state_s   = ST_WRITE;
                  awvalid_s = 1'b1;
                  wvalid_s  = 1'b1;
                  aw_done_s = 1'b0;
                  w_done_s  = 1'b0;
               end else begin
                  state_s   = ST_READ;
                  arvalid_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (awvalid_r && m_axil_awready) begin
               awvalid_s = 1'b0;
               aw_done_s = 1'b1;
            end else begin
               aw_done_s = aw_done_r;
            end
            if (wvalid_r && m_axil_wready) begin
               wvalid_s = 1'b0;
               w_done_s = 1'b1;
            end else begin
               w_done_s = w_done_r;
            end
            if (aw_done_s && w_done_s) begin
               state_s   = ST_W_RESP;
               bready_s  = 1'b1;
               aw_done_s = 1'b0;
               w_done_s  = 1'b0;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_W_RESP: begin
            if (m_axil_bvalid && bready_r) begin
               state_s  = ST_IDLE;
               bready_s = 1'b0;
               ready_s  = 1'b1;
               error_s  = resp_is_err(m_axil_bresp);
            end else begin
               state_s = ST_W_RESP;
            end
         end
         ST_READ: begin
            if (arvalid_r && m_axil_arready) begin
               state_s   = ST_R_DATA;
               arvalid_s = 1'b0;
               rready_s  = 1'b1;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_R_DATA: begin
            if (m_axil_rvalid && rready_r) begin
               state_s  = ST_IDLE;
               rready_s = 1'b0;
               rdata_s  = m_axil_rdata;
               ready_s  = 1'b1;
               error_s  = resp_is_err(m_axil_rresp);
            end else begin
               state_s = ST_R_DATA;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            awvalid_s = 1'b0;
            wvalid_s  = 1'b0;
            arvalid_s = 1'b0;
            bready_s  = 1'b0;
            rready_s  = 1'b0;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
         end
      endcase
   end

   // State and registered-output update; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         arvalid_r <= 1'b0;
         bready_r  <= 1'b0;
         rready_r  <= 1'b0;
         ready_r   <= 1'b0;
         error_r   <= 1'b0;
         rdata_r   <= {AXIL_DATA_W{1'b0}};
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         awvalid_r <= awvalid_s;
         wvalid_r  <= wvalid_s;
         arvalid_r <= arvalid_s;
         bready_r  <= bready_s;
         rready_r  <= rready_s;
         ready_r   <= ready_s;
         error_r   <= error_s;
         rdata_r   <= rdata_s;
         aw_done_r <= aw_done_s;
         w_done_r  <= w_done_s;
      end
   end

endmodule

// File: tb/tb_native2axil_adapter.sv
// Directed bench for native2axil_adapter: a table of native requests against a
// delay-programmable AXI4-lite slave model, plus skew and reset sequences.
module tb_native2axil_adapter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic [31:0] rdata;
   logic        ready, error;
   logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
   logic [2:0]  m_axil_awprot, m_axil_arprot;
   logic [3:0]  m_axil_wstrb;
   logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [1:0]  m_axil_bresp, m_axil_rresp;
   logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic        m_axil_rvalid, m_axil_rready;

   always #5 clk = ~clk;

   native2axil_adapter #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
      .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready), .error(error),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
   );

   // ---------------- AXI4-lite slave model ----------------
   logic [31:0] mem [0:63];
   int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
   logic [1:0] bresp_v = 2'b00, rresp_v = 2'b00;
   logic b_hold = 1'b0;
   int aw_wait, w_wait, ar_wait, b_wait, r_wait;
   logic aw_got, w_got, rd_pend;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic [3:0]  wr_strb;
   int cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r, cnt_ready;

   assign m_axil_awready = m_axil_awvalid && !aw_got && (aw_wait >= aw_dly);
   assign m_axil_wready  = m_axil_wvalid && !w_got && (w_wait >= w_dly);
   assign m_axil_bvalid  = aw_got && w_got && !b_hold && (b_wait >= b_dly);
   assign m_axil_bresp   = bresp_v;
   assign m_axil_arready = m_axil_arvalid && !rd_pend && (ar_wait >= ar_dly);
   assign m_axil_rvalid  = rd_pend && (r_wait >= r_dly);
   assign m_axil_rdata   = mem[rd_addr[7:2]];
   assign m_axil_rresp   = rresp_v;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
   end

   always @(posedge clk) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; rd_pend <= 1'b0;
         wr_addr <= 32'd0; wr_data <= 32'd0; wr_strb <= 4'd0; rd_addr <= 32'd0;
      end else begin
         if (m_axil_awvalid && m_axil_awready) begin
            aw_got <= 1'b1; aw_wait <= 0; wr_addr <= m_axil_awaddr;
         end else if (m_axil_awvalid && !aw_got) aw_wait <= aw_wait + 1;
         if (m_axil_wvalid && m_axil_wready) begin
            w_got <= 1'b1; w_wait <= 0; wr_data <= m_axil_wdata; wr_strb <= m_axil_wstrb;
         end else if (m_axil_wvalid && !w_got) w_wait <= w_wait + 1;
         if (m_axil_bvalid && m_axil_bready) begin
            for (int i = 0; i < 4; i++)
               if (wr_strb[i]) mem[wr_addr[7:2]][8*i +: 8] <= wr_data[8*i +: 8];
            aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
         end else if (aw_got && w_got && !b_hold) b_wait <= b_wait + 1;
         if (m_axil_arvalid && m_axil_arready) begin
            rd_pend <= 1'b1; ar_wait <= 0; rd_addr <= m_axil_araddr;
         end else if (m_axil_arvalid && !rd_pend) ar_wait <= ar_wait + 1;
         if (m_axil_rvalid && m_axil_rready) begin
            rd_pend <= 1'b0; r_wait <= 0;
         end else if (rd_pend) r_wait <= r_wait + 1;
      end
   end

   // Handshake and completion counters used to detect duplicated transactions.
   always @(posedge clk) begin
      if (rst) begin
         cnt_aw <= 0; cnt_w <= 0; cnt_b <= 0; cnt_ar <= 0; cnt_r <= 0; cnt_ready <= 0;
      end else begin
         if (m_axil_awvalid && m_axil_awready) cnt_aw <= cnt_aw + 1;
         if (m_axil_wvalid && m_axil_wready)   cnt_w <= cnt_w + 1;
         if (m_axil_bvalid && m_axil_bready)   cnt_b <= cnt_b + 1;
         if (m_axil_arvalid && m_axil_arready) cnt_ar <= cnt_ar + 1;
         if (m_axil_rvalid && m_axil_rready)   cnt_r <= cnt_r + 1;
         if (ready) cnt_ready <= cnt_ready + 1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request; returns in the cycle after ready with valid still high.
   task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic rdy_after);
      valid = 1'b1; addr = a; wdata = d; wstrb = s;
      lat = 0; rd = 32'd0; er = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = n; rd = rdata; er = error;
            break;
         end
      end
      @(posedge clk); #1;
      rdy_after = ready;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  bresp;
      logic [1:0]  rresp;
      int          aw_d, w_d, ar_d, r_d, b_d;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   int          lat;
   logic [31:0] rd;
   logic        er, rdy_after;
   int          n_wr, n_rd;
   int          aw0, w0, b0, rdy0;

   initial begin
      vecs[0] = '{32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0, 1'b0};
      vecs[1] = '{32'h10, 32'h0,        4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{32'h20, 32'h12345678, 4'hF, 2'b10, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0, 1'b1};
      vecs[3] = '{32'h20, 32'h0,        4'h0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 3, 32'h12345678, 1'b1};
      vecs[4] = '{32'h10, 32'h0,        4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1'b0};
      vecs[5] = '{32'h04, 32'hCAFEF00D, 4'h3, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0, 1'b0};
      vecs[6] = '{32'h04, 32'h0,        4'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 32'h0000F00D, 1'b0};
      vecs[7] = '{32'h08, 32'hAABBCCDD, 4'hF, 2'b00, 2'b00, 3, 0, 0, 0, 0, 6, 32'h0, 1'b0};
      vecs[8] = '{32'h08, 32'h0,        4'h0, 2'b00, 2'b00, 0, 0, 2, 1, 0, 6, 32'hAABBCCDD, 1'b0};
      vecs[9] = '{32'h0C, 32'h11223344, 4'hF, 2'b00, 2'b00, 0, 2, 0, 0, 1, 6, 32'h0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_error", {31'd0, error}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_valids", {29'd0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 32'd0);
      check("reset_readies", {30'd0, m_axil_bready, m_axil_rready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_no_activity", cnt_aw + cnt_w + cnt_ar + cnt_ready, 32'd0);

      // Back-to-back table: each request is issued in the cycle after the previous ready.
      n_wr = 0; n_rd = 0;
      for (int i = 0; i < 10; i++) begin
         aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; ar_dly = vecs[i].ar_d;
         r_dly = vecs[i].r_d; b_dly = vecs[i].b_d;
         bresp_v = vecs[i].bresp; rresp_v = vecs[i].rresp;
         if (vecs[i].wstrb != 4'd0) n_wr++; else n_rd++;
         run_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rd, er, rdy_after);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_error", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_ready_pulse", i), {31'd0, rdy_after}, 32'd0);
         if (vecs[i].wstrb == 4'd0) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
      valid = 1'b0;
      aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0;
      bresp_v = 2'b00; rresp_v = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("table_aw_count", cnt_aw, n_wr);
      check("table_w_count", cnt_w, n_wr);
      check("table_b_count", cnt_b, n_wr);
      check("table_ar_count", cnt_ar, n_rd);
      check("table_r_count", cnt_r, n_rd);
      check("table_ready_count", cnt_ready, n_wr + n_rd);
      check("mem_0x10", mem[4], 32'hDEADBEEF);
      check("mem_0x0C", mem[3], 32'h11223344);

      // Skewed write: awready withheld 3 cycles, W accepted immediately.
      aw_dly = 3;
      aw0 = cnt_aw; w0 = cnt_w; b0 = cnt_b; rdy0 = cnt_ready;
      valid = 1'b1; addr = 32'h30; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
      @(posedge clk); #1;
      check("skew_c1_valids", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd3);
      check("skew_awaddr", m_axil_awaddr, 32'h30);
      @(posedge clk); #1;
      check("skew_c2_valids", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd2);
      @(posedge clk); #1;
      check("skew_c3_valids", {30'd0, m_axil_awvalid, m_axil_wvalid}, 32'd2);
      lat = 0;
      for (int n = 4; n <= 30; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = n;
            break;
         end
      end
      check("skew_latency", lat, 6);
      valid = 1'b0;
      aw_dly = 0;
      repeat (4) @(posedge clk);
      #1;
      check("skew_one_aw", cnt_aw - aw0, 1);
      check("skew_one_w", cnt_w - w0, 1);
      check("skew_one_b", cnt_b - b0, 1);
      check("skew_one_ready", cnt_ready - rdy0, 1);

      // Reset while waiting for a withheld B response.
      b_hold = 1'b1;
      valid = 1'b1; addr = 32'h38; wdata = 32'h0BADF00D; wstrb = 4'hF;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (m_axil_bready) begin
            lat = n;
            break;
         end
      end
      check("rst_reach_wresp", lat, 2);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      check("rst_outputs", {26'd0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                            m_axil_bready, m_axil_rready, ready}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst = 1'b0; b_hold = 1'b0;
      @(posedge clk); #1;
      run_req(32'h10, 32'h0, 4'h0, lat, rd, er, rdy_after);
      valid = 1'b0;
      check("post_rst_latency", lat, 3);
      check("post_rst_rdata", rd, 32'hDEADBEEF);
      check("post_rst_error", {31'd0, er}, 32'd0);
      check("post_rst_ready_pulse", {31'd0, rdy_after}, 32'd0);
      check("post_rst_no_write", cnt_aw + cnt_b, 32'd0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
